mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
- Multi-cycle control FSM for the MIPS datapath. It sequences one instruction at a time through FETCH, DECODE, EXE, MEM and WB.
- It decodes the same instruction subset as the single-cycle decoder: addu, subu, ori, lui, lw, sw, beq, jal, jr, sll, slt, sra, sltiu, lh, lhu, lb, lbu, sh, sb.
- It drives all datapath enables and muxes per state, and stalls on a shared memory ready handshake.
- It keeps a retired-instruction counter.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- instr  in  32  IR contents; valid from DECODE onward.
- zero  in  1  ALU equality flag, used for beq in EXE.
- mem_ready  in  1  memory completes the access this cycle.
- state  out  3  FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4.
- ir_write  out  1  load IR.
- pc_write  out  1  load PC.
- pc_src  out  2  00 PC+4; 01 branch target; 10 jal target; 11 GPR[rs].
- mem_read  out  1  memory read request (instruction or data).
- mem_write  out  1  data memory write request.
- store_type  out  2  00 word; 01 half; 10 byte.
- dm_ext_op  out  3  000 word; 001 lbu; 010 lb; 011 lhu; 100 lh.
- reg_write  out  1  GPR write enable.
- reg_dst  out  2  00 rt; 01 rd; 10 $31.
- mem_to_reg  out  2  00 ALU result; 01 memory data; 10 PC+4.
- alu_src  out  1  0 register; 1 extended immediate.
- alu_op  out  3  000 add; 001 sub; 010 or; 011 slt; 100 sltu; 101 sll; 110 sra; 111 pass-B.
- ext_op  out  2  00 zero; 01 sign; 10 upper (imm<<16).
- illegal  out  1  one-cycle pulse in DECODE for an unrecognised encoding.
- retire  out  1  one-cycle pulse on the last cycle of an instruction.
- instr_cnt  out  CNT_W  count of retired instructions.

Behaviour:
- Reset (synchronous): state<=FETCH, instr_cnt<=0. In any cycle with reset=1, every write enable (ir_write, pc_write, reg_write, mem_write) and retire/illegal are forced to 0. Reset mid-instruction abandons it with no partial write.
- All outputs are combinational from state and the decode of instr. Registers are only state and instr_cnt.
- Default values when not listed below: all enables 0, all mux selects 0.
- FETCH: mem_read=1. When mem_ready=1: ir_write=1, pc_write=1 (pc_src=00), next state DECODE. Otherwise hold in FETCH.
- DECODE:
  - jal: next WB.
  - Unrecognised encoding: illegal=1, retire=1, next FETCH, instruction skipped.
  - All others: next EXE.
- EXE:
  - alu_src, alu_op and ext_op are valid for the decoded instruction. ext_op=01 for loads, stores, beq and sltiu; 10 for lui; 00 otherwise.
  - beq: alu_op=sub; pc_write=zero; pc_src=01; retire=1; next FETCH.
  - jr: pc_write=1; pc_src=11; retire=1; next FETCH.
  - Loads and stores: next MEM.
  - All others: next WB.
- MEM: EXE's alu_src/alu_op/ext_op values are held stable.
  - Loads: mem_read=1, dm_ext_op set. When mem_ready=1, next WB.
  - Stores: mem_write=1, store_type set. When mem_ready=1, retire=1 and next FETCH.
  - While mem_ready=0: hold in MEM, keep the request asserted.
- WB: reg_write=1, retire=1, next FETCH.
  - R-type: reg_dst=01.
  - Immediate ops and loads: reg_dst=00.
  - Loads: mem_to_reg=01.
  - jal: reg_dst=10, mem_to_reg=10, pc_write=1, pc_src=10.
- Cycles per instruction with zero wait states: beq/jr 3, jal 3, ALU 4, store 4, load 5, illegal 2. Each cycle mem_ready is low adds one cycle in FETCH or MEM.
- instr_cnt increments on every retire, including illegal. It wraps to 0 from all-ones.
- mem_ready is ignored outside FETCH and MEM.
- Invalid state encodings 5..7 go to FETCH on the next edge.

Test Plan:
- Reset, then addu $3,$1,$2 (0x00221821) with mem_ready=1: states 0,1,2,4,0. In WB, reg_write=1, reg_dst=01, alu_op=000. retire pulses once; instr_cnt=1.
- lw $4,8($0) (0x8C040008) with mem_ready low for 2 cycles in MEM: MEM lasts 3 cycles with mem_read=1 throughout. Then WB with mem_to_reg=01, dm_ext_op=000. Total 7 cycles.
- beq (0x10000003) with zero=1, then again with zero=0: EXE pc_write=1, pc_src=01 when taken; pc_write=0 when not. Both return to FETCH after 3 cycles.
- jal 0x0C000010: states 0,1,4. In WB, reg_write=1, reg_dst=10, mem_to_reg=10, pc_write=1, pc_src=10.
- Illegal opcode 0xFC000000: illegal=1 for one cycle in DECODE, no write enables asserted, next state FETCH, instr_cnt increments.
- sb (0xA0010000) with mem_ready=0, reset asserted in MEM: mem_write=0 in the reset cycle, state=0 next, instr_cnt=0.

Source files
------------

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXE/MEM/WB, drives datapath
// enables and mux selects from state plus instruction decode, and counts retired instructions.
module mc_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [2:0]       state,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             mem_read,
  output logic             mem_write,
  output logic [1:0]       store_type,
  output logic [2:0]       dm_ext_op,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             alu_src,
  output logic [2:0]       alu_op,
  output logic [1:0]       ext_op,
  output logic             illegal,
  output logic             retire,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [2:0] AOP_ADD  = 3'b000;
  localparam logic [2:0] AOP_SUB  = 3'b001;
  localparam logic [2:0] AOP_OR   = 3'b010;
  localparam logic [2:0] AOP_SLT  = 3'b011;
  localparam logic [2:0] AOP_SLTU = 3'b100;
  localparam logic [2:0] AOP_SLL  = 3'b101;
  localparam logic [2:0] AOP_SRA  = 3'b110;
  localparam logic [2:0] AOP_PASS = 3'b111;

  state_t state_q, state_d;
  logic [5:0] opc, fn;
  logic d_legal, d_rtype, d_imm, d_load, d_store, d_beq, d_jr, d_jal;
  logic [2:0] d_alu_op, d_dm_ext;
  logic [1:0] d_ext_op, d_store_type;
  logic d_alu_src;
  logic ir_write_c, pc_write_c, reg_write_c, mem_write_c, illegal_c, retire_c;
  logic unused_instr_bits;

  assign opc = instr[31:26];
  assign fn  = instr[5:0];
  assign unused_instr_bits = ^instr[25:6];
  assign state = state_q;

  // Instruction decode: classification plus the ALU/extender/memory attributes it implies
  always_comb begin
    d_legal = 1'b1;  d_rtype = 1'b0; d_imm = 1'b0; d_load = 1'b0;
    d_store = 1'b0;  d_beq = 1'b0;   d_jr = 1'b0;  d_jal = 1'b0;
    d_alu_op = AOP_ADD; d_alu_src = 1'b0; d_ext_op = 2'b00;
    d_store_type = 2'b00; d_dm_ext = 3'b000;
    case (opc)
      6'h00: begin
        d_rtype = 1'b1;
        case (fn)
          6'h21: d_alu_op = AOP_ADD;
          6'h23: d_alu_op = AOP_SUB;
          6'h00: d_alu_op = AOP_SLL;
          6'h2A: d_alu_op = AOP_SLT;
          6'h03: d_alu_op = AOP_SRA;
          6'h08: begin d_rtype = 1'b0; d_jr = 1'b1; end
          default: begin d_rtype = 1'b0; d_legal = 1'b0; end
        endcase
      end
      6'h0D: begin d_imm = 1'b1; d_alu_op = AOP_OR;   d_alu_src = 1'b1; end
      6'h0F: begin d_imm = 1'b1; d_alu_op = AOP_PASS; d_alu_src = 1'b1; d_ext_op = 2'b10; end
      6'h0B: begin d_imm = 1'b1; d_alu_op = AOP_SLTU; d_alu_src = 1'b1; d_ext_op = 2'b01; end
      6'h23: begin d_load = 1'b1; d_alu_src = 1'b1; d_ext_op = 2'b01; d_dm_ext = 3'b000; end
      6'h24: begin d_load = 1'b1; d_alu_src = 1'b1; d_ext_op = 2'b01; d_dm_ext = 3'b001; end
      6'h20: begin d_load = 1'b1; d_alu_src = 1'b1; d_ext_op = 2'b01; d_dm_ext = 3'b010; end
      6'h25: begin d_load = 1'b1; d_alu_src = 1'b1; d_ext_op = 2'b01; d_dm_ext = 3'b011; end
      6'h21: begin d_load = 1'b1; d_alu_src = 1'b1; d_ext_op = 2'b01; d_dm_ext = 3'b100; end
      6'h2B: begin d_store = 1'b1; d_alu_src = 1'b1; d_ext_op = 2'b01; d_store_type = 2'b00; end
      6'h29: begin d_store = 1'b1; d_alu_src = 1'b1; d_ext_op = 2'b01; d_store_type = 2'b01; end
      6'h28: begin d_store = 1'b1; d_alu_src = 1'b1; d_ext_op = 2'b01; d_store_type = 2'b10; end
      6'h04: begin d_beq = 1'b1; d_alu_op = AOP_SUB; d_ext_op = 2'b01; end
      6'h03: d_jal = 1'b1;
      default: d_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = S_FETCH;
    ir_write_c = 1'b0; pc_write_c = 1'b0; reg_write_c = 1'b0; mem_write_c = 1'b0;
    illegal_c = 1'b0;  retire_c = 1'b0;
    pc_src = 2'b00; mem_read = 1'b0; store_type = 2'b00; dm_ext_op = 3'b000;
    reg_dst = 2'b00; mem_to_reg = 2'b00; alu_src = 1'b0; alu_op = AOP_ADD; ext_op = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        if (d_jal) begin
          state_d = S_WB;
        end else if (!d_legal) begin
          illegal_c = 1'b1;
          retire_c  = 1'b1;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        alu_src = d_alu_src; alu_op = d_alu_op; ext_op = d_ext_op;
        if (d_beq) begin
          pc_write_c = zero; pc_src = 2'b01; retire_c = 1'b1;
        end else if (d_jr) begin
          pc_write_c = 1'b1; pc_src = 2'b11; retire_c = 1'b1;
        end else if (d_load || d_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      // Request stays asserted and the ALU address stays stable until memory responds
      S_MEM: begin
        alu_src = d_alu_src; alu_op = d_alu_op; ext_op = d_ext_op;
        if (d_load)  begin mem_read = 1'b1;    dm_ext_op = d_dm_ext; end
        if (d_store) begin mem_write_c = 1'b1; store_type = d_store_type; end
        if (!mem_ready) begin
          state_d = S_MEM;
        end else if (d_store) begin
          retire_c = 1'b1;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        reg_write_c = 1'b1;
        retire_c    = 1'b1;
        if (d_rtype) reg_dst = 2'b01;
        if (d_load)  mem_to_reg = 2'b01;
        if (d_jal) begin
          reg_dst = 2'b10; mem_to_reg = 2'b10; pc_write_c = 1'b1; pc_src = 2'b10;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset suppresses every side effect so an abandoned instruction leaves no partial write
  assign ir_write  = ir_write_c  & ~reset;
  assign pc_write  = pc_write_c  & ~reset;
  assign reg_write = reg_write_c & ~reset;
  assign mem_write = mem_write_c & ~reset;
  assign illegal   = illegal_c   & ~reset;
  assign retire    = retire_c    & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      instr_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (retire_c) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: per-instruction phase lists walked against random mem_ready,
// with expected outputs derived per phase from an instruction attribute table.
module tb_mc_controller;

  localparam int TB_CNT_W = 4;

  localparam logic [2:0] C_R = 3'd0, C_I = 3'd1, C_LD = 3'd2, C_ST = 3'd3;
  localparam logic [2:0] C_BEQ = 3'd4, C_JR = 3'd5, C_JAL = 3'd6, C_ILL = 3'd7;

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] fn;
    logic [2:0] cls;
    logic [2:0] aop;
    logic       asrc;
    logic [1:0] ext;
    logic [1:0] st;
    logic [2:0] dm;
  } vec_t;

  typedef struct packed {
    logic [2:0] state;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] store_type;
    logic [2:0] dm_ext_op;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src;
    logic [2:0] alu_op;
    logic [1:0] ext_op;
    logic       illegal;
    logic       retire;
  } outs_t;

  logic clk, reset, zero, mem_ready;
  logic [31:0] instr;
  logic [2:0] state, dm_ext_op, alu_op;
  logic ir_write, pc_write, mem_read, mem_write, reg_write, alu_src, illegal, retire;
  logic [1:0] pc_src, store_type, reg_dst, mem_to_reg, ext_op;
  logic [TB_CNT_W-1:0] instr_cnt;

  outs_t obs;
  vec_t tbl [22];
  logic [TB_CNT_W-1:0] exp_cnt;
  int n_checks, n_fail;

  mc_controller #(.CNT_W(TB_CNT_W)) dut (
    .clk(clk), .reset(reset), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .state(state), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .mem_read(mem_read), .mem_write(mem_write), .store_type(store_type),
    .dm_ext_op(dm_ext_op), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src(alu_src), .alu_op(alu_op), .ext_op(ext_op),
    .illegal(illegal), .retire(retire), .instr_cnt(instr_cnt)
  );

  assign obs = {state, ir_write, pc_write, pc_src, mem_read, mem_write, store_type,
                dm_ext_op, reg_write, reg_dst, mem_to_reg, alu_src, alu_op, ext_op,
                illegal, retire};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 2000000", $time);
    $fatal(1);
  end

  // Expected outputs for one cycle of a given phase (0..4 = FETCH..WB)
  function automatic outs_t model_out(int p, int k, logic z, logic mr, logic rst);
    outs_t o;
    vec_t v;
    o = '0;
    v = tbl[k];
    o.state = 3'(p);
    case (p)
      0: begin o.mem_read = 1'b1; o.ir_write = mr; o.pc_write = mr; end
      1: if (v.cls == C_ILL) begin o.illegal = 1'b1; o.retire = 1'b1; end
      2, 3: begin
        o.alu_src = v.asrc; o.alu_op = v.aop; o.ext_op = v.ext;
        if (p == 2 && v.cls == C_BEQ) begin o.pc_write = z; o.pc_src = 2'b01; o.retire = 1'b1; end
        if (p == 2 && v.cls == C_JR) begin o.pc_write = 1'b1; o.pc_src = 2'b11; o.retire = 1'b1; end
        if (p == 3 && v.cls == C_LD) begin o.mem_read = 1'b1; o.dm_ext_op = v.dm; end
        if (p == 3 && v.cls == C_ST) begin o.mem_write = 1'b1; o.store_type = v.st; o.retire = mr; end
      end
      default: begin
        o.reg_write = 1'b1; o.retire = 1'b1;
        if (v.cls == C_R) o.reg_dst = 2'b01;
        if (v.cls == C_LD) o.mem_to_reg = 2'b01;
        if (v.cls == C_JAL) begin
          o.reg_dst = 2'b10; o.mem_to_reg = 2'b10; o.pc_write = 1'b1; o.pc_src = 2'b10;
        end
      end
    endcase
    if (rst) begin
      o.ir_write = 1'b0; o.pc_write = 1'b0; o.reg_write = 1'b0;
      o.mem_write = 1'b0; o.illegal = 1'b0; o.retire = 1'b0;
    end
    return o;
  endfunction

  function automatic logic [31:0] mk_instr(int k);
    logic [31:0] r;
    r = $urandom;
    if (tbl[k].op == 6'h00) return {6'h00, r[25:6], tbl[k].fn};
    return {tbl[k].op, r[25:0]};
  endfunction

  task automatic check_out(input outs_t exp, input string nm);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (state got %0d required %0d)", nm, obs, exp, obs.state, exp.state);
    end
  endtask

  task automatic check_cnt(input string nm);
    n_checks++;
    if (instr_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL %s instr_cnt: got %0d required %0d", nm, instr_cnt, exp_cnt);
    end
  endtask

  // Walk one instruction's phase list; FETCH/MEM advance only on mem_ready.
  // fw/mw: low mem_ready cycles in FETCH/MEM (directed), rnd: random mem_ready,
  // rst_at: cycle index at which reset is asserted (-1 none)
  task automatic run_instr(input int k, input logic [31:0] w, input logic z,
                           input int fw, input int mw, input bit rnd, input int rst_at);
    int ph[$];
    int pi, cyc, lows, p;
    logic mr, ze, rs;
    string nm;
    case (tbl[k].cls)
      C_R, C_I:     ph = '{0, 1, 2, 4};
      C_LD:         ph = '{0, 1, 2, 3, 4};
      C_ST:         ph = '{0, 1, 2, 3};
      C_BEQ, C_JR:  ph = '{0, 1, 2};
      C_JAL:        ph = '{0, 1, 4};
      default:      ph = '{0, 1};
    endcase
    pi = 0; cyc = 0; lows = 0;
    while (pi < ph.size()) begin
      @(negedge clk);
      p  = ph[pi];
      ze = (p == 2) ? z : 1'($urandom);
      rs = (cyc == rst_at);
      if (rnd) mr = (lows >= 8) ? 1'b1 : ($urandom_range(0, 2) != 0);
      else if (p == 0) mr = (lows < fw) ? 1'b0 : 1'b1;
      else if (p == 3) mr = (lows < mw) ? 1'b0 : 1'b1;
      else mr = 1'($urandom);
      instr = (p == 0) ? $urandom : w;
      zero = ze; mem_ready = mr; reset = rs;
      #1;
      nm = $sformatf("k%0d_%h_ph%0d_c%0d", k, w, p, cyc);
      check_out(model_out(p, k, ze, mr, rs), nm);
      check_cnt(nm);
      if (rs) begin
        exp_cnt = '0;
        pi = ph.size();
      end else begin
        if (model_out(p, k, ze, mr, 1'b0).retire) exp_cnt = exp_cnt + 1'b1;
        if ((p == 0 || p == 3) && !mr) lows++;
        else begin pi++; lows = 0; end
      end
      cyc++;
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; exp_cnt = '0;
    reset = 1'b1; instr = '0; zero = 1'b0; mem_ready = 1'b0;

    // op, fn, class, alu_op, alu_src, ext_op, store_type, dm_ext_op
    tbl[0]  = '{6'h00, 6'h21, C_R,   3'd0, 1'b0, 2'd0, 2'd0, 3'd0}; // addu
    tbl[1]  = '{6'h00, 6'h23, C_R,   3'd1, 1'b0, 2'd0, 2'd0, 3'd0}; // subu
    tbl[2]  = '{6'h00, 6'h00, C_R,   3'd5, 1'b0, 2'd0, 2'd0, 3'd0}; // sll
    tbl[3]  = '{6'h00, 6'h2A, C_R,   3'd3, 1'b0, 2'd0, 2'd0, 3'd0}; // slt
    tbl[4]  = '{6'h00, 6'h03, C_R,   3'd6, 1'b0, 2'd0, 2'd0, 3'd0}; // sra
    tbl[5]  = '{6'h00, 6'h08, C_JR,  3'd0, 1'b0, 2'd0, 2'd0, 3'd0}; // jr
    tbl[6]  = '{6'h0D, 6'h00, C_I,   3'd2, 1'b1, 2'd0, 2'd0, 3'd0}; // ori
    tbl[7]  = '{6'h0F, 6'h00, C_I,   3'd7, 1'b1, 2'd2, 2'd0, 3'd0}; // lui
    tbl[8]  = '{6'h0B, 6'h00, C_I,   3'd4, 1'b1, 2'd1, 2'd0, 3'd0}; // sltiu
    tbl[9]  = '{6'h23, 6'h00, C_LD,  3'd0, 1'b1, 2'd1, 2'd0, 3'd0}; // lw
    tbl[10] = '{6'h21, 6'h00, C_LD,  3'd0, 1'b1, 2'd1, 2'd0, 3'd4}; // lh
    tbl[11] = '{6'h25, 6'h00, C_LD,  3'd0, 1'b1, 2'd1, 2'd0, 3'd3}; // lhu
    tbl[12] = '{6'h20, 6'h00, C_LD,  3'd0, 1'b1, 2'd1, 2'd0, 3'd2}; // lb
    tbl[13] = '{6'h24, 6'h00, C_LD,  3'd0, 1'b1, 2'd1, 2'd0, 3'd1}; // lbu
    tbl[14] = '{6'h2B, 6'h00, C_ST,  3'd0, 1'b1, 2'd1, 2'd0, 3'd0}; // sw
    tbl[15] = '{6'h29, 6'h00, C_ST,  3'd0, 1'b1, 2'd1, 2'd1, 3'd0}; // sh
    tbl[16] = '{6'h28, 6'h00, C_ST,  3'd0, 1'b1, 2'd1, 2'd2, 3'd0}; // sb
    tbl[17] = '{6'h04, 6'h00, C_BEQ, 3'd1, 1'b0, 2'd1, 2'd0, 3'd0}; // beq
    tbl[18] = '{6'h03, 6'h00, C_JAL, 3'd0, 1'b0, 2'd0, 2'd0, 3'd0}; // jal
    tbl[19] = '{6'h3F, 6'h00, C_ILL, 3'd0, 1'b0, 2'd0, 2'd0, 3'd0}; // bad opcode
    tbl[20] = '{6'h00, 6'h01, C_ILL, 3'd0, 1'b0, 2'd0, 2'd0, 3'd0}; // bad funct
    tbl[21] = '{6'h02, 6'h00, C_ILL, 3'd0, 1'b0, 2'd0, 2'd0, 3'd0}; // j (unsupported)

    // Reset: second reset cycle is in FETCH with all side effects suppressed
    @(negedge clk); mem_ready = 1'b1;
    @(negedge clk); mem_ready = 1'b1; instr = $urandom;
    #1;
    check_out(model_out(0, 0, 1'b0, 1'b1, 1'b1), "reset_fetch");
    check_cnt("reset");

    // Every table entry once with no wait states
    for (int k = 0; k < 22; k++) run_instr(k, mk_instr(k), 1'($urandom), 0, 0, 1'b0, -1);

    // Directed multi-cycle corner cases
    run_instr(0,  32'h00221821, 1'b0, 0, 0, 1'b0, -1);  // addu
    run_instr(9,  32'h8C040008, 1'b0, 0, 2, 1'b0, -1);  // lw, 2 wait cycles in MEM
    run_instr(17, 32'h10000003, 1'b1, 0, 0, 1'b0, -1);  // beq taken
    run_instr(17, 32'h10000003, 1'b0, 0, 0, 1'b0, -1);  // beq not taken
    run_instr(18, 32'h0C000010, 1'b0, 0, 0, 1'b0, -1);  // jal
    run_instr(19, 32'hFC000000, 1'b0, 0, 0, 1'b0, -1);  // illegal
    run_instr(14, mk_instr(14), 1'b0, 3, 1, 1'b0, -1);  // fetch waits then store wait
    run_instr(16, 32'hA0010000, 1'b0, 0, 3, 1'b0, 3);   // sb, reset while stalled in MEM

    // Randomized instructions, mem_ready and occasional resets; counter wraps repeatedly
    for (int i = 0; i < 150; i++) begin
      int k, ra;
      k  = $urandom_range(0, 21);
      ra = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 5) : -1;
      run_instr(k, mk_instr(k), 1'($urandom), 0, 0, 1'b1, ra);
    end

    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b0; instr = $urandom;
    #1;
    check_out(model_out(0, 0, 1'b0, 1'b0, 1'b0), "final_fetch");
    check_cnt("final");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
